// File: rtl/rnbip_ctrl_seq.sv
// rnbip_ctrl_seq - fetch/decode/execute sequencer for the RNBIP-2 datapath.
//
// Owns the PC, the instruction register and the immediate register (OR2).
// It drives the register file's write controls and the ALU opcode, and it
// runs the byte-wide instruction-memory fetch handshake.
//
// Ports:
//   clk        in   system clock, rising edge
//   clr        in   synchronous active-high reset; also forces we=0 at once
//   mem_addr   out  8  fetch address (= PC)
//   mem_rd     out  fetch request (FETCH, IMM)
//   mem_ack    in   fetch data valid (ignored while mem_rd=0)
//   mem_data   in   8  fetched byte
//   we         out  register-file write enable (EXEC only)
//   mux_sel    out  3  register-file write-source select (111 = no write)
//   read_seg   out  3  register-file B-port read index
//   write_seg  out  3  register-file write index
//   or2        out  8  immediate register
//   alu_op     out  3  ALU operation (= IR[5:3])
//   ir         out  8  current instruction
//   halted     out  high while in HALT
module rnbip_ctrl_seq #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       clr,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic       we,
  output logic [2:0] mux_sel,
  output logic [2:0] read_seg,
  output logic [2:0] write_seg,
  output logic [7:0] or2,
  output logic [2:0] alu_op,
  output logic [7:0] ir,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_IMM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_or2;

  logic [1:0] w_cls;
  logic [2:0] w_f1;
  logic [2:0] w_f2;
  logic [2:0] w_rsel;
  logic       w_we;

  assign w_cls = r_ir[7:6];
  assign w_f1  = r_ir[5:3];
  assign w_f2  = r_ir[2:0];

  // B-port index is a pure function of IR, so it stays stable from DECODE
  // through EXEC without a separate holding register.
  always_comb begin
    w_rsel = '0;
    if (w_cls == 2'b00 || w_cls == 2'b01)
      w_rsel = w_f2;
    else if (w_cls == 2'b11 && w_f2 == 3'b010)
      w_rsel = w_f1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_FETCH;
      r_pc    <= PC_RESET;
      r_ir    <= '0;
      r_or2   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && mem_ack) begin
        r_ir <= mem_data;
        r_pc <= r_pc + 8'd1;
      end
      if (r_state == S_IMM && mem_ack) begin
        r_or2 <= mem_data;
        r_pc  <= r_pc + 8'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ack) w_next = S_DECODE;
      S_DECODE: begin
        if (w_cls == 2'b10)
          w_next = S_IMM;
        else if (w_cls == 2'b11 && w_f2 == 3'b111)
          w_next = S_HALT;
        else
          w_next = S_EXEC;
      end
      S_IMM:    if (mem_ack) w_next = S_EXEC;
      S_EXEC:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_we      = 1'b0;
    mux_sel   = 3'b111;
    write_seg = '0;
    read_seg  = '0;
    mem_rd    = 1'b0;
    case (r_state)
      S_FETCH:  mem_rd = 1'b1;
      S_DECODE: read_seg = w_rsel;
      S_IMM: begin
        mem_rd   = 1'b1;
        read_seg = w_rsel;
      end
      S_EXEC: begin
        read_seg = w_rsel;
        case (w_cls)
          2'b00: begin
            w_we      = 1'b1;
            mux_sel   = 3'b001;
            write_seg = w_f1;
          end
          2'b01: begin
            w_we    = 1'b1;
            mux_sel = 3'b011;
          end
          2'b10: begin
            w_we      = 1'b1;
            mux_sel   = 3'b010;
            write_seg = w_f1;
          end
          default: begin
            if (w_f2 == 3'b001) begin
              w_we    = 1'b1;
              mux_sel = 3'b100;
            end else if (w_f2 == 3'b010) begin
              w_we    = 1'b1;
              mux_sel = 3'b101;
            end
          end
        endcase
      end
      default: ;
    endcase
  end

  // clr suppresses the write in the same cycle, ahead of the synchronous reset.
  assign we       = w_we & ~clr;
  assign mem_addr = r_pc;
  assign or2      = r_or2;
  assign alu_op   = w_f1;
  assign ir       = r_ir;
  assign halted   = (r_state == S_HALT);

endmodule
